rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource between up to four masters. It produces a registered one-hot grant and the 2-bit encoded grant index that drives the shared datapath's select, matching the team's 4-to-2 encoder mapping. The grant is held while the owner keeps requesting. An optional timeout forces release so one master cannot starve the others.

---
 rtl/rr_arbiter4_if.sv | 15 +
 rtl/rr_arbiter4.sv | 77 +++++++
 tb/tb_rr_arbiter4.sv | 81 ++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between four masters and the round-robin arbiter
//   req       [3:0] level-sensitive requests, bit i = master i
//   gnt       [3:0] registered one-hot grant, zero when idle
//   gnt_id    [1:0] encoded grant index (1->00, 2->01, 4->10, 8->11)
//   gnt_valid       high exactly when gnt is non-zero
//   modport master: drives req, observes grant
//   modport slave : the arbiter side
interface rr_arbiter4_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   modport master (output req, input gnt, gnt_id, gnt_valid);
   modport slave  (input req, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with held grants and optional hold timeout
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rr_arbiter4_if.slave (req in; gnt, gnt_id, gnt_valid out)
//   MAX_HOLD, CNT_W  hold limit and counter width, used only when
//   RR_ARBITER4_TIMEOUT_EN is defined (forces release after MAX_HOLD cycles)
module rr_arbiter4 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input logic          clk,
   input logic          rst,
   rr_arbiter4_if.slave bus
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     state, state_n;
   logic [1:0] owner, owner_n, ptr, ptr_n, win;
   logic [3:0] elig;
   logic       win_ok, rel, tmo;
   if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_max_hold
      $error("rr_arbiter4: MAX_HOLD out of range 2..2^CNT_W");
   end
   // The current owner is masked whenever it gives up the grant, even if it
   // re-raises its request in the same cycle.
   always_comb begin
      elig   = (state == GRANT) ? bus.req & ~(4'b0001 << owner) : bus.req;
      win_ok = 1'b0;
      win    = ptr;
      // Scan from the far end so the nearest requester to ptr wins.
      for (int i = 3; i >= 0; i--) begin
         if (elig[ptr + 2'(i)]) begin
            win_ok = 1'b1;
            win    = ptr + 2'(i);
         end
      end
   end
`ifdef RR_ARBITER4_TIMEOUT_EN
   logic [CNT_W-1:0] cnt, cnt_n;
   assign tmo   = (state == GRANT) && (cnt == CNT_W'(MAX_HOLD - 1)) && |elig;
   // Restart on any re-arbitration; wrap at MAX_HOLD-1 when nobody else waits.
   assign cnt_n = (rel || cnt == CNT_W'(MAX_HOLD - 1)) ? '0 : cnt + CNT_W'(1);
`else
   assign tmo = 1'b0;
`endif
   always_comb begin
      state_n = state;
      owner_n = owner;
      ptr_n   = ptr;
      rel     = (state == IDLE) || !bus.req[owner] || tmo;
      if (rel) begin
         state_n = win_ok ? GRANT : IDLE;
         owner_n = win_ok ? win : owner;
         ptr_n   = win_ok ? win + 2'd1 : ptr;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= 2'd0;
         ptr   <= 2'd0;
`ifdef RR_ARBITER4_TIMEOUT_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_n;
         owner <= owner_n;
         ptr   <= ptr_n;
`ifdef RR_ARBITER4_TIMEOUT_EN
         cnt   <= cnt_n;
`endif
      end
   end
   // All three outputs decode the same registered state, so they never disagree.
   assign bus.gnt       = (state == GRANT) ? 4'b0001 << owner : 4'b0000;
   assign bus.gnt_id    = (state == GRANT) ? owner : 2'd0;
   assign bus.gnt_valid = (state == GRANT);
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed scoreboard bench for rr_arbiter4
module tb_rr_arbiter4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [3:0] exp_q[$];
   rr_arbiter4_if bus ();
   rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
`ifdef RR_ARBITER4_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif
   function automatic logic [1:0] enc(input logic [3:0] g);
      return g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
   endfunction
   task automatic step(input logic r_st, input logic [3:0] r, input logic [3:0] e, input string tag);
      logic [3:0] x;
      @(negedge clk);
      rst     = r_st;
      bus.req = r;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      checks++;
      assert (bus.gnt === x) else begin
         failures++;
         $error("FAIL %s gnt=%b expected=%b", tag, bus.gnt, x);
      end
      checks++;
      assert (bus.gnt_id === enc(x)) else begin
         failures++;
         $error("FAIL %s gnt_id=%b expected=%b", tag, bus.gnt_id, enc(x));
      end
      checks++;
      assert (bus.gnt_valid === (x != 4'b0000)) else begin
         failures++;
         $error("FAIL %s gnt_valid=%b expected=%b", tag, bus.gnt_valid, x != 4'b0000);
      end
   endtask
   initial begin
      bus.req = 4'b1111;
      step(1'b1, 4'b1111, 4'b0000, "reset_hold0");
      step(1'b1, 4'b1111, 4'b0000, "reset_hold1");
      step(1'b0, 4'b1111, 4'b0001, "reset_release");
      step(1'b0, 4'b1111, 4'b0001, "rot_hold0");
      step(1'b0, 4'b1110, 4'b0010, "rot_to1");
      step(1'b0, 4'b1111, 4'b0010, "rot_hold1");
      step(1'b0, 4'b1101, 4'b0100, "rot_to2");
      step(1'b0, 4'b1111, 4'b0100, "rot_hold2");
      step(1'b0, 4'b1011, 4'b1000, "rot_to3");
      step(1'b0, 4'b1111, 4'b1000, "rot_hold3");
      step(1'b0, 4'b0111, 4'b0001, "rot_wrap0");
      step(1'b0, 4'b0000, 4'b0000, "release_idle");
      step(1'b0, 4'b0100, 4'b0100, "ptr_pick2");
      step(1'b0, 4'b0000, 4'b0000, "ptr_idle");
      step(1'b0, 4'b1001, 4'b1000, "ptr_is3");
      step(1'b0, 4'b0010, 4'b0010, "mask_grant1");
      step(1'b0, 4'b1011, 4'b0010, "mask_toggle_a");
      step(1'b0, 4'b0010, 4'b0010, "mask_toggle_b");
      step(1'b0, 4'b1011, 4'b0010, "mask_toggle_c");
      step(1'b0, 4'b0010, 4'b0010, "mask_toggle_d");
      step(1'b0, 4'b1001, 4'b1000, "mask_release");
      step(1'b0, 4'b0100, 4'b0100, "mid_grant2");
      step(1'b0, 4'b1111, 4'b0100, "mid_hold2");
      step(1'b1, 4'b1111, 4'b0000, "mid_reset");
      step(1'b0, 4'b1111, 4'b0001, "mid_after_reset");
      step(1'b0, 4'b0000, 4'b0000, "tmo_idle");
      step(1'b0, 4'b0001, 4'b0001, "tmo_grant0");
      step(1'b0, 4'b0101, 4'b0001, "tmo_hold1");
      step(1'b0, 4'b0101, 4'b0001, "tmo_hold2");
      step(1'b0, 4'b0101, 4'b0001, "tmo_hold3");
      step(1'b0, 4'b0101, TMO ? 4'b0100 : 4'b0001, "tmo_fire");
      step(1'b0, 4'b0101, TMO ? 4'b0100 : 4'b0001, "tmo_after");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
